// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes stage: SBOX_N bytes substituted per cycle, valid/ready on both sides.
// Define AES_SUBBYTES_INV_EN to add the inv port and the inverse S-box table.
module sub_bytes_seq #(
    parameter int unsigned SBOX_N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] st_in,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_SUBBYTES_INV_EN
    input  logic         inv,
`endif
    output logic [127:0] sb
);

    localparam int unsigned NGroups = 16 / SBOX_N;
    localparam int unsigned CntW    = (NGroups > 1) ? $clog2(NGroups) : 1;
    localparam int unsigned GrpW    = 8 * SBOX_N;

    if (!(SBOX_N == 1 || SBOX_N == 2 || SBOX_N == 4 || SBOX_N == 8 || SBOX_N == 16))
    begin : g_bad_sbox_n
        $error("sub_bytes_seq: SBOX_N must be 1, 2, 4, 8 or 16");
    end

    // Entry 0 sits in the top byte of each table.
    localparam logic [2047:0] FwdTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return FwdTbl[idx +: 8];
    endfunction

`ifdef AES_SUBBYTES_INV_EN
    localparam logic [2047:0] InvTbl = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return InvTbl[idx +: 8];
    endfunction

    logic inv_q;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [127:0]    work_q;
    logic [127:0]    sb_q;
    logic            out_valid_q;

    logic            accept;
    logic [6:0]      grp_lsb;
    logic [GrpW-1:0] grp_in;
    logic [GrpW-1:0] grp_out;
    logic [127:0]    work_sub;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign sb        = sb_q;

    // Group 0 holds the most significant bytes.
    always_comb begin
        grp_lsb  = 7'(128 - GrpW * (int'(cnt_q) + 1));
        grp_in   = work_q[grp_lsb +: GrpW];
        work_sub = work_q;
        work_sub[grp_lsb +: GrpW] = grp_out;
    end

    for (genvar i = 0; i < SBOX_N; i++) begin : g_sbox
        logic [7:0] b_in;
        assign b_in = grp_in[8*i +: 8];
`ifdef AES_SUBBYTES_INV_EN
        assign grp_out[8*i +: 8] = inv_q ? inv_sbox(b_in) : fwd_sbox(b_in);
`else
        assign grp_out[8*i +: 8] = fwd_sbox(b_in);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            work_q      <= '0;
            sb_q        <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_SUBBYTES_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: ;
                StBusy: begin
                    work_q <= work_sub;
                    if (cnt_q == CntW'(NGroups - 1)) begin
                        sb_q        <= work_sub;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Acceptance overrides the DONE->IDLE move so back-to-back states see no bubble.
            if (accept) begin
                work_q  <= st_in;
                cnt_q   <= '0;
                state_q <= StBusy;
`ifdef AES_SUBBYTES_INV_EN
                inv_q   <= inv;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: three instances (SBOX_N = 4, 1, 16) driven from a vector table
// plus hand-written stall, back-to-back, reset-abort and (optional) inverse sequences.
module tb_sub_bytes_seq;

    localparam int NDut = 3;
    localparam int NVec = 6;

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NDut];
    logic         in_ready  [NDut];
    logic [127:0] st_in     [NDut];
    logic         out_valid [NDut];
    logic         out_ready [NDut];
    logic [127:0] sb        [NDut];
`ifdef AES_SUBBYTES_INV_EN
    logic         inv       [NDut];
    logic         inv_mode = 1'b0;
`endif

    vec_t tbl [NVec];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sub_bytes_seq #(.SBOX_N(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .st_in(st_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
`ifdef AES_SUBBYTES_INV_EN
        .inv(inv[0]),
`endif
        .sb(sb[0])
    );

    sub_bytes_seq #(.SBOX_N(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .st_in(st_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
`ifdef AES_SUBBYTES_INV_EN
        .inv(inv[1]),
`endif
        .sb(sb[1])
    );

    sub_bytes_seq #(.SBOX_N(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .st_in(st_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
`ifdef AES_SUBBYTES_INV_EN
        .inv(inv[2]),
`endif
        .sb(sb[2])
    );

    function automatic int lat(input int d);
        case (d)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [dut%0d]: got %h, want %h", name, d, act, exp);
        end
    endtask

    task automatic wait_valid(input int d, input int budget, output int cycles);
        cycles = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (out_valid[d]) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input int d, input logic [127:0] din, input logic [127:0] exp);
        int cyc;
        @(negedge clk);
        chk("idle in_ready", d, 128'(in_ready[d]), 128'(1));
        in_valid[d]  = 1'b1;
        st_in[d]     = din;
        out_ready[d] = 1'b1;
`ifdef AES_SUBBYTES_INV_EN
        inv[d] = inv_mode;
`endif
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        st_in[d]    = '0;
`ifdef AES_SUBBYTES_INV_EN
        inv[d] = !inv_mode;
`endif
        wait_valid(d, lat(d) + 4, cyc);
        chk("latency", d, 128'(cyc), 128'(lat(d)));
        chk("sb", d, sb[d], exp);
        @(posedge clk); #1;
        chk("out_valid drop", d, 128'(out_valid[d]), 128'(0));
        chk("sb hold", d, sb[d], exp);
        chk("in_ready after", d, 128'(in_ready[d]), 128'(1));
    endtask

    // The accept lands in the DONE cycle, so results arrive every lat+1 edges.
    task automatic run_b2b(input int d);
        int idx, got, budget;
        int t [3];
        logic acc;
        idx    = 0;
        got    = 0;
        t      = '{0, 0, 0};
        budget = 3 * (lat(d) + 1) + 6;
        @(negedge clk);
        in_valid[d]  = 1'b1;
        st_in[d]     = tbl[0].din;
        out_ready[d] = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            acc = in_valid[d] && in_ready[d];
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) st_in[d] = tbl[idx].din;
                else in_valid[d] = 1'b0;
            end
            if (out_valid[d] && got < 3) begin
                chk("b2b sb", d, sb[d], tbl[got].exp);
                t[got] = c;
                got++;
            end
            if (got == 3) break;
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
        chk("b2b count", d, 128'(got), 128'(3));
        chk("b2b first latency", d, 128'(t[0]), 128'(lat(d) + 1));
        chk("b2b gap 1", d, 128'(t[1] - t[0]), 128'(lat(d) + 1));
        chk("b2b gap 2", d, 128'(t[2] - t[1]), 128'(lat(d) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        tbl[1] = '{128'h0, {16{8'h63}}};
        tbl[2] = '{{16{8'hff}}, {16{8'h16}}};
        tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
        tbl[4] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h8ca1890dbfe6426841992d0fb054bb16};
        tbl[5] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};

        rst = 1'b1;
        for (int d = 0; d < NDut; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            st_in[d]     = '0;
`ifdef AES_SUBBYTES_INV_EN
            inv[d] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < NDut; d++) begin
            chk("reset out_valid", d, 128'(out_valid[d]), 128'(0));
            chk("reset sb", d, sb[d], 128'h0);
            chk("reset in_ready", d, 128'(in_ready[d]), 128'(1));
        end

        for (int d = 0; d < NDut; d++)
            for (int i = 0; i < NVec; i++)
                run_vec(d, tbl[i].din, tbl[i].exp);

        // Output stall: result holds while a new in_valid is ignored
        @(negedge clk);
        in_valid[0]  = 1'b1;
        st_in[0]     = 128'h0;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        st_in[0] = {16{8'hff}};
        wait_valid(0, 8, cyc);
        chk("stall latency", 0, 128'(cyc), 128'(4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall sb", 0, sb[0], {16{8'h63}});
            chk("stall out_valid", 0, 128'(out_valid[0]), 128'(1));
            chk("stall in_ready", 0, 128'(in_ready[0]), 128'(0));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        #1;
        chk("done in_ready", 0, 128'(in_ready[0]), 128'(1));
        @(posedge clk); #1;
        chk("release out_valid", 0, 128'(out_valid[0]), 128'(0));
        chk("release in_ready", 0, 128'(in_ready[0]), 128'(1));
        chk("release sb", 0, sb[0], {16{8'h63}});

        for (int d = 0; d < NDut; d++) run_b2b(d);

        // Reset two cycles into a transaction discards it
        @(negedge clk);
        in_valid[0]  = 1'b1;
        st_in[0]     = tbl[3].din;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", 0, 128'(out_valid[0]), 128'(0));
        chk("abort sb", 0, sb[0], 128'h0);
        chk("abort in_ready", 0, 128'(in_ready[0]), 128'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort no out_valid", 0, 128'(out_valid[0]), 128'(0));
        end
        run_vec(0, tbl[0].din, tbl[0].exp);

`ifdef AES_SUBBYTES_INV_EN
        inv_mode = 1'b1;
        for (int d = 0; d < NDut; d++) begin
            run_vec(d, {16{8'h63}}, 128'h0);
            run_vec(d, tbl[0].exp, tbl[0].din);
        end
        inv_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
